ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter: sends one command byte (0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard.

---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_sync.sv | 44 ++++
 rtl/ps2_host_tx.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared PS/2 definitions used by the host transmitter (ps2_host_tx) and the
// device-to-host receiver (KeyboardDecoder):
//   ps2_tx_state_t  transmitter FSM states
//   ERR_*           2-bit error codes reported on err_code
//   CMD_*           keyboard command bytes the host sends
//   max3()          helper used to size counters from the largest timing parameter
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_ERR       = 3'd6
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_BIT   = 2'b10;
    localparam logic [1:0] ERR_NOACK = 2'b11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
// Brings the asynchronous PS2_CLK / PS2_DATA pin levels into the clk domain
// through two flops each, and flags a falling edge of the synchronised PS/2
// clock by comparing it with its previous sample.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   ps2_clk_in    raw PS2_CLK pin level
//   ps2_data_in   raw PS2_DATA pin level
//   clk_sync      synchronised PS2_CLK
//   data_sync     synchronised PS2_DATA
//   clk_fall      one-cycle strobe: synchronised PS2_CLK went 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [1:0] clk_meta;
    logic [1:0] data_meta;
    logic       clk_prev;

    // Reset to the idle (released, pulled-up) level so leaving reset never
    // produces a phantom falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk_in};
            data_meta <= {data_meta[0], ps2_data_in};
            clk_prev  <= clk_meta[1];
        end
    end

    assign clk_sync  = clk_meta[1];
    assign data_sync = data_meta[1];
    assign clk_fall  = clk_prev & ~clk_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// then shifts one command byte (LSB first, odd parity, stop) on the device's
// clock and checks the device ACK. The open-drain lines are driven through
// registered active-high pull-low enables.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   tx_valid      command byte available
//   tx_data       command byte, latched on accept (tx_valid & tx_ready)
//   tx_ready      high only while idle
//   ps2_clk_in    raw PS2_CLK pin level
//   ps2_data_in   raw PS2_DATA pin level
//   ps2_clk_oe    1 = pull PS2_CLK low
//   ps2_data_oe   1 = pull PS2_DATA low
//   busy          high from accept until back in idle
//   done          one-cycle pulse: frame sent and ACK received
//   err           one-cycle pulse: frame aborted
//   err_code      ERR_* code of the last abort, cleared on next accept
// Configuration macro: PS2_TX_RETRY_EN -- when defined, bit-timeout and
// no-ACK failures re-send the latched byte up to two more times before err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC       = 12000,
    parameter int START_TIMEOUT_CYC = 1500000,
    parameter int BIT_TIMEOUT_CYC   = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int MAX_CYC = max3(INHIBIT_CYC, START_TIMEOUT_CYC, BIT_TIMEOUT_CYC);
    localparam int TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] TMR_MAX    = TW'(MAX_CYC);
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] INH_PRE    = TW'(INHIBIT_CYC - 2);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(BIT_TIMEOUT_CYC - 1);

    ps2_tx_state_t state_q, state_d;

    logic [TW-1:0] timer_q, timer_d;
    logic          timer_clr;
    logic [3:0]    fall_cnt_q, fall_cnt_d;
    logic [7:0]    data_q, data_d;
    logic          par_q, par_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          fail;
    logic [1:0]    fail_code;
    logic          retry_taken;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]    retry_q, retry_d;
`endif

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (clk_sync),
        .data_sync   (data_sync),
        .clk_fall    (clk_fall)
    );

    // Next-state and next-output logic. Every stage that waits on the device
    // raises 'fail' with a code; the common tail decides between retry and
    // abort so the timeout rules live in one place.
    always_comb begin
        state_d     = state_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        data_d      = data_q;
        par_d       = par_q;
        fall_cnt_d  = fall_cnt_q;
        timer_clr   = 1'b0;
        fail        = 1'b0;
        fail_code   = ERR_NONE;
        retry_taken = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d    = ST_INHIBIT;
                    data_d     = tx_data;
                    par_d      = ~^tx_data;
                    fall_cnt_d = 4'd0;
                    err_code_d = ERR_NONE;
                    clk_oe_d   = 1'b1;
                    timer_clr  = 1'b1;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = 2'd0;
`endif
                end
            end

            // Outputs are registered, so data is asserted one cycle early to
            // land on the final inhibit cycle.
            ST_INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    state_d   = ST_REQ;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    timer_clr = 1'b1;
                end else if (timer_q == INH_PRE) begin
                    data_oe_d = 1'b1;
                end
            end

            // The first device falling edge is edge 1: present data bit 0.
            ST_REQ: begin
                if (clk_fall) begin
                    state_d    = ST_DATA;
                    fall_cnt_d = 4'd1;
                    data_oe_d  = ~data_q[0];
                    timer_clr  = 1'b1;
                end else if (timer_q == START_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_START;
                end
            end

            // fall_cnt_q holds the edges seen so far, so the new edge number
            // is fall_cnt_q+1 and the data bit it carries is d[fall_cnt_q].
            ST_DATA: begin
                if (clk_fall) begin
                    fall_cnt_d = fall_cnt_q + 4'd1;
                    timer_clr  = 1'b1;
                    if (fall_cnt_q <= 4'd7) begin
                        data_oe_d = ~data_q[fall_cnt_q[2:0]];
                    end else if (fall_cnt_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                end else if (timer_q == BIT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT;
                end
            end

            ST_ACK: begin
                if (clk_fall) begin
                    fall_cnt_d = (fall_cnt_q == 4'd11) ? fall_cnt_q : fall_cnt_q + 4'd1;
                    timer_clr  = 1'b1;
                    if (!data_sync) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_NOACK;
                    end
                end else if (timer_q == BIT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT;
                end
            end

            ST_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    timer_clr = 1'b1;
                end else if (timer_q == BIT_LAST) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT;
                end
            end

            ST_ERR: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                timer_clr = 1'b1;
            end

            default: begin
                state_d   = ST_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                timer_clr = 1'b1;
            end
        endcase

        // Start timeouts mean no device is listening, so they never retry.
        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if ((fail_code != ERR_START) && (retry_q != 2'd2)) begin
                retry_taken = 1'b1;
                retry_d     = retry_q + 2'd1;
                state_d     = ST_INHIBIT;
                clk_oe_d    = 1'b1;
                data_oe_d   = 1'b0;
                fall_cnt_d  = 4'd0;
                timer_clr   = 1'b1;
            end
`endif
            if (!retry_taken) begin
                state_d    = ST_ERR;
                clk_oe_d   = 1'b0;
                data_oe_d  = 1'b0;
                err_d      = 1'b1;
                err_code_d = fail_code;
                timer_clr  = 1'b1;
            end
        end
    end

    // Shared stage timer: restarts on every state change and device edge,
    // and parks at its top value instead of wrapping.
    always_comb begin
        if (timer_clr) begin
            timer_d = '0;
        end else if (timer_q == TMR_MAX) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Registered state and outputs; reset releases both lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            fall_cnt_q <= 4'd0;
            data_q     <= 8'd0;
            par_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fall_cnt_q <= fall_cnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q <= 2'd0;
        end else begin
            retry_q <= retry_d;
        end
    end
`endif

    assign tx_ready    = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Bench for ps2_host_tx with short timing parameters and a behavioural
// keyboard on the open-drain lines. The keyboard clocks the frame, records
// what the host drives on each falling edge and answers with ACK or NACK;
// expected bit patterns come from the frame format (LSB first, odd parity,
// released stop bit).
module tb_ps2_host_tx;

    localparam int INH   = 20;
    localparam int START = 400;
    localparam int BITTO = 100;
    localparam int HALF  = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int N_FRAMES = 3;
`else
    localparam int N_FRAMES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYC       (INH),
        .START_TIMEOUT_CYC (START),
        .BIT_TIMEOUT_CYC   (BITTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int oe_hi_cnt = 0;
    int overlap_cnt = 0;
    int snap_done, snap_err, snap_hi;
    int fall_cyc;
    logic [11:1] rec_oe;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and level bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (ps2_clk_oe) oe_hi_cnt <= oe_hi_cnt + 1;
        if (done && err) overlap_cnt <= overlap_cnt + 1;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Expected pull-low enable per device falling edge for byte b.
    function automatic logic [11:1] expected_oe(input logic [7:0] b);
        int v;
        int ones;
        int bitv;
        logic [11:1] e;
        v = int'(b);
        ones = 0;
        e = '0;
        for (int n = 1; n <= 8; n++) begin
            bitv = (v >> (n - 1)) % 2;
            ones += bitv;
            e[n] = (bitv == 0);
        end
        e[9] = (ones % 2) == 1;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        #1;
        snap_done = done_cnt;
        snap_err  = err_cnt;
        snap_hi   = oe_hi_cnt;
        tx_valid  = 1'b1;
        tx_data   = b;
        @(posedge clk);
        #1;
        tx_valid  = 1'b0;
        tx_data   = 8'($urandom);
    endtask

    // Keyboard: waits for request-to-send, then clocks n_edges falling edges,
    // recording the host's data drive late in each low phase.
    task automatic device_frame(input int n_edges, input bit ack_low, output bit ok);
        ok = 1'b0;
        rec_oe = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        repeat (30) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11) dev_data_low = ack_low;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            rec_oe[e] = ps2_data_oe;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clk);
            if (e == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        #1;
        checkOutput(tag, 32'(tx_ready), 32'd1);
    endtask

    initial begin
        bit ok;
        bit seen;
        int n;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        checkOutput("rst_pulses", 32'({done, err}), 32'd0);
        checkOutput("rst_err_code", 32'(err_code), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1: set-LEDs command, keyboard ACKs
        $display("[TB] test 1: send 0xED with ACK");
        applyStimulus(8'hED);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        device_frame(11, 1'b1, ok);
        checkOutput("t1_rts_seen", 32'(ok), 32'd1);
        wait_idle("t1_idle", 200);
        checkOutput("t1_clk_oe_cycles", 32'(oe_hi_cnt - snap_hi), 32'(INH));
        checkOutput("t1_oe_bits_const", 32'(rec_oe), 32'h012);
        checkOutput("t1_oe_bits_model", 32'(rec_oe), 32'(expected_oe(8'hED)));
        checkOutput("t1_done", 32'(done_cnt - snap_done), 32'd1);
        checkOutput("t1_no_err", 32'(err_cnt - snap_err), 32'd0);
        checkOutput("t1_err_code", 32'(err_code), 32'd0);

        // Random command bytes, each ACKed
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            $display("[TB] random frame 0x%02h", b);
            applyStimulus(b);
            device_frame(11, 1'b1, ok);
            wait_idle("rnd_idle", 200);
            checkOutput("rnd_oe_bits", 32'(rec_oe), 32'(expected_oe(b)));
            checkOutput("rnd_done", 32'(done_cnt - snap_done), 32'd1);
        end

        // 2: reset command, keyboard never clocks
        $display("[TB] test 2: send 0xFF, no device clock");
        applyStimulus(8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t2_clk_release", 32'(seen), 32'd1);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n++;
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t2_err_seen", 32'(seen), 32'd1);
        checkOutput("t2_req_cycles", 32'(n), 32'(START));
        checkOutput("t2_err_code", 32'(err_code), 32'd1);
        checkOutput("t2_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        @(negedge clk);
        checkOutput("t2_tx_ready", 32'(tx_ready), 32'd1);

        // 3: enable command, keyboard stops after 5 edges; the host sees the
        // pin edge 3 cycles late through the synchroniser.
        $display("[TB] test 3: send 0xF4, device stalls after 5 edges");
        applyStimulus(8'hF4);
        for (int f = 0; f < N_FRAMES; f++) device_frame(5, 1'b1, ok);
        checkOutput("t3_rts_seen", 32'(ok), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("t3_err_seen", 32'(seen), 32'd1);
        checkOutput("t3_timeout_delay", 32'(cyc - fall_cyc), 32'(BITTO + 3));
        checkOutput("t3_err_code", 32'(err_code), 32'd2);
        wait_idle("t3_idle", 50);
        checkOutput("t3_err_once", 32'(err_cnt - snap_err), 32'd1);

        // 4: 0x00 (parity 1), keyboard NACKs
        $display("[TB] test 4: send 0x00, device NACKs");
        applyStimulus(8'h00);
        for (int f = 0; f < N_FRAMES; f++) begin
            device_frame(11, 1'b0, ok);
            checkOutput("t4_oe_bits", 32'(rec_oe), 32'(expected_oe(8'h00)));
        end
        wait_idle("t4_idle", 200);
        checkOutput("t4_err_once", 32'(err_cnt - snap_err), 32'd1);
        checkOutput("t4_no_done", 32'(done_cnt - snap_done), 32'd0);
        checkOutput("t4_err_code", 32'(err_code), 32'd3);

        // 5: asynchronous reset mid-frame after edge 4 (bit 3 forced to 0 so
        // the host is pulling data low when reset hits)
        $display("[TB] test 5: reset during DATA");
        b = 8'($urandom) & 8'hF7;
        applyStimulus(b);
        device_frame(4, 1'b1, ok);
        repeat (3) @(negedge clk);
        #2;
        checkOutput("t5_pre_data_oe", 32'(ps2_data_oe), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t5_oe_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t5_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_no_pulses", 32'((done_cnt - snap_done) + (err_cnt - snap_err)), 32'd0);

        // 6: tx_valid with 0x55 while busy is ignored
        $display("[TB] test 6: request while busy");
        b = 8'($urandom);
        if (b == 8'h55) b = 8'hAA;
        applyStimulus(b);
        fork
            device_frame(11, 1'b1, ok);
            begin
                repeat (100) @(negedge clk);
                tx_valid = 1'b1;
                tx_data  = 8'h55;
                repeat (3) @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        wait_idle("t6_idle", 200);
        checkOutput("t6_oe_bits", 32'(rec_oe), 32'(expected_oe(b)));
        checkOutput("t6_done_once", 32'(done_cnt - snap_done), 32'd1);
        repeat (INH + 5) @(negedge clk);
        #1;
        checkOutput("t6_no_new_frame", 32'(oe_hi_cnt - snap_hi), 32'(INH));
        checkOutput("t6_still_idle", 32'(tx_ready), 32'd1);

        checkOutput("done_err_exclusive", 32'(overlap_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
